// File: rtl/vector_processor.sv
// vector_processor: 4-lane 8.8 fixed-point vector ALU, one shared multiplier
// Optional LERP opcode 6 enabled by defining VP_LERP_EN
module vector_processor #(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4,
  parameter int FRAC_BITS    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [3:0]                         operation,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vec_a,
  input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] vec_b,
  input  logic [DATA_WIDTH-1:0]              scalar,
  output logic                               busy,
  output logic                               done,
  output logic [DATA_WIDTH*VECTOR_WIDTH-1:0] result,
  output logic                               result_valid
);

  localparam int DW = DATA_WIDTH;
  localparam int VW = DATA_WIDTH*VECTOR_WIDTH;
  localparam int PW = 2*DW+2;
  localparam int LW = $clog2(VECTOR_WIDTH);
  localparam int RW = DW+3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LANE = 2'd1;
  localparam logic [1:0] S_SQRT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DOT  = 4'd3;
  localparam logic [3:0] OP_SCL  = 4'd4;
  localparam logic [3:0] OP_LEN  = 4'd5;
  localparam logic [3:0] OP_LERP = 4'd6;

  localparam logic [DW-1:0] W_ONE = DW'(1) << FRAC_BITS;
  localparam logic [DW-1:0] W_MAX = '1;

  logic [1:0]           r_state;
  logic [3:0]           r_op;
  logic [VW-1:0]        r_a;
  logic [VW-1:0]        r_b;
  logic [DW-1:0]        r_s;
  logic [LW-1:0]        r_lane;
  logic [VW-1:0]        r_shadow;
  logic [VW-1:0]        r_result;
  logic signed [PW-1:0] r_acc;
  logic [PW-1:0]        r_rad;
  logic [RW-1:0]        r_rem;
  logic [DW:0]          r_root;
  logic [4:0]           r_cnt;

  logic [DW-1:0]        w_la;
  logic [DW-1:0]        w_lb;
  logic signed [DW:0]   w_ma;
  logic signed [DW:0]   w_mb;
  logic signed [PW-1:0] w_prod;
  logic [DW:0]          w_sum;
  logic [DW-1:0]        w_lr;
  logic [VW-1:0]        w_shadow_nxt;
  logic signed [PW-1:0] w_acc_nxt;
  logic signed [PW-1:0] w_dsh;
  logic [DW-1:0]        w_dot;
  logic                 w_pass2;
  logic                 w_start_lane;
  logic [RW+1:0]        w_rem_sh;
  logic [RW+1:0]        w_trial;
  logic                 w_ge;
  logic [RW+1:0]        w_rem_nx;
  logic [DW:0]          w_root_nx;
  logic [DW-1:0]        w_sqrt;

  assign w_la = r_a[r_lane*DW +: DW];
  assign w_lb = r_b[r_lane*DW +: DW];

`ifdef VP_LERP_EN
  logic          r_phase;
  logic [PW-1:0] r_tmp;
  logic [PW-1:0] w_lerp_sum;
  logic          w_lerp;
  logic [DW-1:0] w_s_cl;
  logic [DW-1:0] w_s_inv;

  assign w_lerp     = (r_op == OP_LERP);
  assign w_s_cl     = (r_s > W_ONE) ? W_ONE : r_s;
  assign w_s_inv    = W_ONE - w_s_cl;
  assign w_lerp_sum = r_tmp + w_prod;
  assign w_pass2    = !w_lerp || r_phase;
  assign w_start_lane = (operation <= OP_LERP);

  // LERP first pass parks a*(1-s) until the b*s pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_tmp   <= '0;
    end else if (r_state == S_LANE && w_lerp) begin
      r_phase <= !r_phase;
      if (!r_phase) r_tmp <= w_prod;
    end else begin
      r_phase <= 1'b0;
    end
  end
`else
  assign w_pass2      = 1'b1;
  assign w_start_lane = (operation <= OP_LEN);
`endif

  // operand steering into the single shared multiplier
  always_comb begin
    w_ma = {1'b0, w_la};
    w_mb = {1'b0, w_lb};
    unique case (1'b1)
      (r_op == OP_DOT): begin
        w_ma = {w_la[DW-1], w_la};
        w_mb = {w_lb[DW-1], w_lb};
      end
      (r_op == OP_LEN): begin
        w_ma = {w_la[DW-1], w_la};
        w_mb = {w_la[DW-1], w_la};
      end
      (r_op == OP_SCL): w_mb = {1'b0, r_s};
`ifdef VP_LERP_EN
      (r_op == OP_LERP): begin
        w_ma = r_phase ? {1'b0, w_lb} : {1'b0, w_la};
        w_mb = r_phase ? {1'b0, w_s_cl} : {1'b0, w_s_inv};
      end
`endif
      default: ;
    endcase
  end

  assign w_prod    = w_ma * w_mb;
  assign w_sum     = {1'b0, w_la} + {1'b0, w_lb};
  assign w_acc_nxt = r_acc + w_prod;
  assign w_dsh     = w_acc_nxt >>> FRAC_BITS;

  // per-lane result for the element-wise opcodes
  always_comb begin
    w_lr = '0;
    unique case (1'b1)
      (r_op == OP_ADD):
        w_lr = w_sum[DW] ? W_MAX : w_sum[DW-1:0];
      (r_op == OP_SUB):
        w_lr = (w_la >= w_lb) ? (w_la - w_lb) : '0;
      (r_op == OP_MUL) || (r_op == OP_SCL):
        w_lr = (|w_prod[2*DW-1:DW+FRAC_BITS]) ? W_MAX
             : w_prod[DW+FRAC_BITS-1:FRAC_BITS];
`ifdef VP_LERP_EN
      (r_op == OP_LERP):
        w_lr = w_lerp_sum[DW+FRAC_BITS-1:FRAC_BITS];
`endif
      default: ;
    endcase
  end

  // shadow vector with the current lane replaced
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[r_lane*DW +: DW] = w_lr;
  end

  // DOT: clamp shifted accumulator to signed 16
  always_comb begin
    w_dot = w_dsh[DW-1:0];
    if (!(&w_dsh[PW-1:DW-1]) && (|w_dsh[PW-1:DW-1]))
      w_dot = w_dsh[PW-1] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
  end

  assign w_rem_sh  = {r_rem, r_rad[PW-1:PW-2]};
  assign w_trial   = {1'b0, r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nx = {r_root[DW-1:0], w_ge};
  assign w_sqrt    = w_root_nx[DW] ? W_MAX : w_root_nx[DW-1:0];

  // control FSM with lane sequencing and square-root iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_lane   <= '0;
      r_shadow <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_op     <= operation;
          r_a      <= vec_a;
          r_b      <= vec_b;
          r_s      <= scalar;
          r_lane   <= LW'(VECTOR_WIDTH-1);
          r_shadow <= '0;
          r_acc    <= '0;
          if (w_start_lane) begin
            r_state <= S_LANE;
          end else begin
            r_result <= vec_a;
            r_state  <= S_DONE;
          end
        end
        S_LANE: if (w_pass2) begin
          r_shadow <= w_shadow_nxt;
          r_acc    <= w_acc_nxt;
          if (r_lane == '0) begin
            if (r_op == OP_LEN) begin
              r_rad   <= w_acc_nxt;
              r_rem   <= '0;
              r_root  <= '0;
              r_cnt   <= 5'(DW);
              r_state <= S_SQRT;
            end else begin
              r_result <= (r_op == OP_DOT)
                ? {w_dot, {(VW-DW){1'b0}}} : w_shadow_nxt;
              r_state  <= S_DONE;
            end
          end else begin
            r_lane <= r_lane - LW'(1);
          end
        end
        S_SQRT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_nx[RW-1:0];
          r_root <= w_root_nx;
          if (r_cnt == '0) begin
            r_result <= {w_sqrt, {(VW-DW){1'b0}}};
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign result_valid = (r_state == S_DONE);
  assign result       = r_result;

endmodule

// File: tb/tb_vector_processor.sv
// tb_vector_processor: table vectors, random ops vs. arithmetic model,
// and hand sequences for ignored start and mid-operation reset
module tb_vector_processor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  operation;
  logic [63:0] vec_a;
  logic [63:0] vec_b;
  logic [15:0] scalar;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        result_valid;

  int total;
  int bad;

  vector_processor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .operation   (operation),
    .vec_a       (vec_a),
    .vec_b       (vec_b),
    .scalar      (scalar),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op,
      input logic [63:0] a, input logic [63:0] b, input logic [15:0] s);
    logic [63:0] r;
    longint ai, bi, sa, sb, acc, v, sc;
    r = '0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      ai = longint'(a[16*i +: 16]);
      bi = longint'(b[16*i +: 16]);
      sa = longint'($signed(a[16*i +: 16]));
      sb = longint'($signed(b[16*i +: 16]));
      v = 0;
      case (op)
        4'd0: v = (ai + bi > 65535) ? 65535 : ai + bi;
        4'd1: v = (ai > bi) ? ai - bi : 0;
        4'd2: v = ((ai * bi) >> 8 > 65535) ? 65535 : (ai * bi) >> 8;
        4'd3: acc += sa * sb;
        4'd4: begin
          sc = longint'(s);
          v = ((ai * sc) >> 8 > 65535) ? 65535 : (ai * sc) >> 8;
        end
        4'd5: acc += sa * sa;
`ifdef VP_LERP_EN
        4'd6: begin
          sc = (s > 16'h0100) ? 256 : longint'(s);
          v = (ai * (256 - sc) + bi * sc) >> 8;
        end
`endif
        default: ;
      endcase
      r[16*i +: 16] = v[15:0];
    end
    case (op)
      4'd3: begin
        v = acc >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        r = {v[15:0], 48'h0};
      end
      4'd5: begin
        v = longint'($sqrt(real'(acc)));
        while (v * v > acc) v--;
        while ((v + 1) * (v + 1) <= acc) v++;
        if (v > 65535) v = 65535;
        r = {v[15:0], 48'h0};
      end
`ifdef VP_LERP_EN
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6: ;
`else
      4'd0, 4'd1, 4'd2, 4'd4: ;
`endif
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'd5) return 22;
    if (op <= 4'd4) return 5;
`ifdef VP_LERP_EN
    if (op == 4'd6) return 9;
`endif
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a,
      input logic [63:0] b, input logic [15:0] s,
      input logic [63:0] exp, input int lat);
    int k;
    bit bz_ok;
    @(negedge clk);
    start = 1'b1;
    operation = op;
    vec_a = a;
    vec_b = b;
    scalar = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    operation = 4'($urandom_range(0, 15));
    vec_a = {$urandom, $urandom};
    vec_b = {$urandom, $urandom};
    scalar = 16'($urandom);
    k = 1;
    bz_ok = 1'b1;
    while (!done && k < 40) begin
      if (!busy) bz_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("latency op%0d", op), 64'(k), 64'(lat));
    chk($sformatf("result op%0d", op), result, exp);
    chk($sformatf("valid op%0d", op), {63'd0, result_valid}, 64'd1);
    chk($sformatf("busy op%0d", op), {63'd0, bz_ok & busy}, 64'd1);
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse op%0d", op), {63'd0, done}, 64'd0);
    chk($sformatf("idle op%0d", op), {63'd0, busy}, 64'd0);
    chk($sformatf("hold op%0d", op), result, exp);
  endtask

  initial begin
    int k;
    int ndone;
    logic [3:0] op;
    logic [63:0] a, b;
    logic [15:0] s;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    operation = '0;
    vec_a = '0;
    vec_b = '0;
    scalar = '0;

    tbl.push_back('{4'd4, 64'hFF00_0000_0000_FF00, 64'h0,
                    16'h0080, 64'h7F80_0000_0000_7F80, 5});
    tbl.push_back('{4'd5, 64'h0300_0400_0000_0000, 64'h0,
                    16'h0, 64'h0500_0000_0000_0000, 22});
    tbl.push_back('{4'd5, 64'hFF80_FF80_0000_0000, 64'h0,
                    16'h0, 64'h00B5_0000_0000_0000, 22});
    tbl.push_back('{4'd0, 64'hF000_1234_0000_FFFF,
                    64'h2000_0001_0000_0001,
                    16'h0, 64'hFFFF_1235_0000_FFFF, 5});
    tbl.push_back('{4'd1, 64'h1000_5000_0000_0000,
                    64'h2000_1000_0001_0000,
                    16'h0, 64'h0000_4000_0000_0000, 5});
    tbl.push_back('{4'd2, 64'h0200_FFFF_0100_0000,
                    64'h0300_0200_0080_1234,
                    16'h0, 64'h0600_FFFF_0080_0000, 5});
    tbl.push_back('{4'd3, 64'h0100_0200_0000_0000,
                    64'h0300_0100_0000_0000,
                    16'h0, 64'h0500_0000_0000_0000, 5});
    tbl.push_back('{4'd3, 64'h8000_8000_8000_8000,
                    64'h7FFF_7FFF_7FFF_7FFF,
                    16'h0, 64'h8000_0000_0000_0000, 5});
    tbl.push_back('{4'hF, 64'h0123_4567_89AB_CDEF, 64'h0,
                    16'h0, 64'h0123_4567_89AB_CDEF, 1});
`ifdef VP_LERP_EN
    tbl.push_back('{4'd6, 64'h0000_1111_2222_3333,
                    64'hFF00_0000_0000_0000,
                    16'h0080, 64'h7F80_0888_1111_1999, 9});
`else
    tbl.push_back('{4'd6, 64'h0000_1111_2222_3333,
                    64'hFF00_0000_0000_0000,
                    16'h0080, 64'h0000_1111_2222_3333, 1});
`endif

    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset valid", {63'd0, result_valid}, 64'd0);
    chk("reset result", result, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].s,
             tbl[i].exp, tbl[i].lat);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 8));
      if (op == 4'd8) op = 4'($urandom_range(7, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                      : 16'($urandom_range(0, 300));
      run_op(op, a, b, s, model(op, a, b, s), lat_of(op));
    end

    // second start during LANE and during DONE is ignored
    @(negedge clk);
    start = 1'b1;
    operation = 4'd4;
    vec_a = 64'hFF00_0000_0000_FF00;
    scalar = 16'h0080;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    operation = 4'hF;
    vec_a = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 2;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ign latency", 64'(k), 64'd5);
    chk("ign result", result, 64'h7F80_0000_0000_7F80);
    @(negedge clk);
    start = 1'b1;
    operation = 4'hF;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign done-start busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("ign extra done", 64'(ndone), 64'd0);
    chk("ign result kept", result, 64'h7F80_0000_0000_7F80);

    // reset in cycle 10 of a LENGTH aborts it
    @(negedge clk);
    start = 1'b1;
    operation = 4'd5;
    vec_a = 64'h0300_0400_0000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    chk("abort busy before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    chk("abort valid", {63'd0, result_valid}, 64'd0);
    chk("abort result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);

    run_op(4'd4, 64'hFF00_0000_0000_FF00, 64'h0, 16'h0080,
           64'h7F80_0000_0000_7F80, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
